// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : cam_pattern_gen
// Brief    : Camera-style frame generator (vsync/href/8-bit data, RGB565 fill)
// Revision : 1.0
// ============================================================================
module cam_pattern_gen #(
  parameter int COLS   = 160,
  parameter int ROWS   = 120,
  parameter int HBLANK = 16,
  parameter int VS_CYC = 8,
  parameter int VBP    = 8
) (
  input  logic       p_clock,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] color,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam int LINE_BYTES = 2 * COLS;
  localparam int MAX_A      = (LINE_BYTES > HBLANK) ? LINE_BYTES : HBLANK;
  localparam int MAX_B      = (VS_CYC > VBP) ? VS_CYC : VBP;
  localparam int CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] VS_LAST   = CW'(VS_CYC - 1);
  localparam logic [CW-1:0] VBP_LAST  = CW'(VBP - 1);
  localparam logic [CW-1:0] LINE_LAST = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] HBL_LAST  = CW'(HBLANK - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_VBP   = 3'd2,
    S_LINE  = 3'd3,
    S_HBL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          busy_q, busy_d;
  logic [15:0]   pix;

  assign pix = {col_q[2] ? 5'h1f : 5'h00,
                col_q[1] ? 6'h3f : 6'h00,
                col_q[0] ? 5'h1f : 5'h00};

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          col_d   = color;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = S_VBP;
          cnt_d   = '0;
        end
      end
      S_VBP: begin
        if (cnt_q == VBP_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt_q == LINE_LAST) begin
          cnt_d = '0;
          if (row_q == ROW_LAST) begin
            done_d = 1'b1;
            row_d  = '0;
            if (enable) begin
              state_d = S_VSYNC;
              col_d   = color;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_HBL;
          end
        end
      end
      S_HBL: begin
        if (cnt_q == HBL_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          row_d   = row_q + RW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_LINE);
    busy_d  = (state_d != S_IDLE);
    fcnt_d  = fcnt_q + {7'd0, done_d};
    data_d  = 8'h00;
    if (state_d == S_LINE) begin
      data_d = cnt_d[0] ? pix[7:0] : pix[15:8];
    end
  end

  always_ff @(posedge p_clock) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      fcnt_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
